fifo_ctrl_16x8: RTL

- Synchronous FIFO controller placed directly upstream of the 16x8 dual-port RAM.
- Converts a push/pop stream interface into the RAM's write, read, wr_addr, rd_addr and data_in controls.
- Keeps read/write pointers, occupancy count and status flags, and flags a valid pop one cycle later, when the RAM's registered data_out is valid.
- The RAM stays a separate instance. This block holds no storage beyond pointers and flags.

---
 rtl/fifo_ctrl_16x8.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_ctrl_16x8.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_16x8
// Purpose  : Synchronous FIFO controller sitting in front of a 16x8
//            dual-port RAM. It turns a push/pop stream into RAM write/read
//            strobes and addresses. It keeps the read/write pointers, the
//            occupancy and the status flags. pop_valid marks the cycle in
//            which the RAM's registered data_out holds the popped word.
//            No data storage lives here. The RAM is a separate instance.
//
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous reset, active low
//            push         - write request
//            push_data    - data to store (passed straight to the RAM)
//            pop          - read request
//            clear_err    - synchronous clear of overflow/underflow
//            ram_write    - RAM write strobe
//            ram_wr_addr  - RAM write address
//            ram_data_in  - RAM write data
//            ram_read     - RAM read strobe
//            ram_rd_addr  - RAM read address
//            pop_valid    - RAM data_out holds the popped word this cycle
//            full/empty/almost_full/almost_empty - occupancy flags
//            count        - occupancy, 0..RAM_DEPTH
//            overflow     - sticky: push attempted while full
//            underflow    - sticky: pop attempted while empty
//
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl_16x8 #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 16,
    parameter int ADDR_SIZE = 4,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [RAM_WIDTH-1:0] push_data,
    input  logic                 pop,
    input  logic                 clear_err,
    output logic                 ram_write,
    output logic [ADDR_SIZE-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_SIZE:0] c_af_level = AF_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] c_ae_level = AE_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] c_ptr_zero = '0;

    // The wrap-bit pointer scheme only works when the RAM is exactly a power
    // of two deep.
    generate
        if (RAM_DEPTH != (2 ** ADDR_SIZE)) begin : g_bad_depth
            $error("fifo_ctrl_16x8: RAM_DEPTH must equal 2**ADDR_SIZE");
        end
    endgenerate

    // Pointers carry one extra MSB (wrap bit) to tell full from empty.
    logic [ADDR_SIZE:0] r_wr_ptr;
    logic [ADDR_SIZE:0] r_rd_ptr;
    logic               r_pop_valid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [ADDR_SIZE:0] w_count;

    assign w_full  = (r_wr_ptr[ADDR_SIZE-1:0] == r_rd_ptr[ADDR_SIZE-1:0]) &&
                     (r_wr_ptr[ADDR_SIZE] != r_rd_ptr[ADDR_SIZE]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = r_wr_ptr - r_rd_ptr;

    // Reset is asynchronous, so the RAM strobes are gated by rst directly.
    // A push held during reset must not write the RAM. When full, a push is
    // refused even alongside a pop. Otherwise the RAM would see a
    // same-address read and write.
    assign w_wr_ok = rst & push & ~w_full;
    assign w_rd_ok = rst & pop & ~w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= c_ptr_zero;
            r_rd_ptr    <= c_ptr_zero;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + {{ADDR_SIZE{1'b0}}, w_wr_ok};
            r_rd_ptr    <= r_rd_ptr + {{ADDR_SIZE{1'b0}}, w_rd_ok};
            // The RAM registers data_out on the edge that samples ram_read,
            // so the popped word is visible one cycle after acceptance.
            r_pop_valid <= w_rd_ok;

            // A new error takes priority over a clear in the same cycle.
            if (push && w_full) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end

            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign ram_write    = w_wr_ok;
    assign ram_wr_addr  = r_wr_ptr[ADDR_SIZE-1:0];
    assign ram_data_in  = push_data;
    assign ram_read     = w_rd_ok;
    assign ram_rd_addr  = r_rd_ptr[ADDR_SIZE-1:0];
    assign pop_valid    = r_pop_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= c_af_level);
    assign almost_empty = (w_count <= c_ae_level);
    assign count        = w_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
